ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Arbitrates the single data-RAM port between the CPU data path and a read-only streaming requester (the message output engine that drains decoded text from RAM). One access per clock reaches the RAM. The CPU has default priority. A starvation counter guarantees the stream port a slot at least every MAX_WAIT+1 cycles by stalling the CPU. The block sits between the CPU/chipset RAM-select path and the RAM macro, replacing the direct CPU-to-RAM connection.

## Interface
- ADDR_W, 10, RAM word-address width
- DATA_W, 32, data width
- MAX_WAIT, 8, max consecutive cycles a pending stream request may be refused (1..255)

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cpu_req  in  1  CPU RAM access this cycle (chipset RAM select)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data for the CPU, one cycle after grant
- cpu_stall  out  1  CPU request refused this cycle; CPU holds request and PC
- dma_req  in  1  stream read request; held until granted
- dma_addr  in  ADDR_W  stream read address; stable while dma_req is high
- dma_gnt  out  1  stream request accepted this cycle (combinational)
- dma_rdata  out  DATA_W  stream read data
- dma_valid  out  1  dma_rdata valid; one cycle after dma_gnt
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data (= cpu_wdata)
- ram_we  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data; synchronous, valid the cycle after the address

## Operation
- Grant decision each cycle is combinational, from cpu_req, dma_req and the starvation count wait_cnt.
  - force = dma_req && (wait_cnt == MAX_WAIT).
  - CPU granted iff cpu_req && !force.
  - Stream granted iff dma_req && (!cpu_req || force).
- cpu_stall = cpu_req && !cpu_grant. This is high only on forced cycles, never two cycles in a row, because a forced grant clears wait_cnt.
- ram_addr muxes the granted requester's address; with no grant it holds cpu_addr.
- ram_we = cpu_grant && cpu_we && !rst. The stream port never writes.
- wait_cnt (8 bit, saturating at MAX_WAIT):
  - Cleared on rst, on dma_gnt, or when dma_req is low.
  - Otherwise incremented each cycle dma_req is high but refused.
- Owner register last_owner ∈ {OWN_NONE, OWN_CPU, OWN_DMA}:
  - Loads OWN_CPU for a CPU read grant, OWN_DMA for a stream grant, OWN_NONE otherwise (a write or idle cycle).
  - Steers ram_rdata.
- dma_valid = (last_owner == OWN_DMA). dma_rdata = ram_rdata, masked to 0 when dma_valid is low.
- cpu_rdata = ram_rdata when last_owner == OWN_CPU, else 0.
- Simultaneous forced slot and CPU write: the write is stalled, not dropped. It completes the next cycle because cpu_req is still held.

## Timing
- Reset values: wait_cnt=0, last_owner=OWN_NONE, dma_valid=0, cpu_rdata=0, dma_rdata=0. ram_we=0 during any rst cycle, including mid-operation.
- Read latency: 1 cycle from grant to cpu_rdata/dma_valid for both ports.
- Write: committed at the clock edge ending the grant cycle.
- Stream starvation bound: with cpu_req continuously high, a pending dma_req is granted on its (MAX_WAIT+1)th cycle.
- Reset asserted the cycle after a stream grant: dma_valid is 0 in the following cycle and that read is discarded; the stream engine re-requests.
- Back-to-back stream grants while the CPU is idle give dma_valid high every cycle.

## Structure
- Shared package ram_arb_pkg: typedef enum logic [1:0] owner_t {OWN_NONE, OWN_CPU, OWN_DMA}, and the MAX_WAIT default constant.
- One sub-module, starve_counter: parameter MAX_WAIT; inputs clk, rst, pending, granted; output at_limit.
- Grant logic, muxes and the owner register live in ram_arbiter.

## Test plan
- Reset: rst high for 2 cycles during an active cpu_req/cpu_we -> ram_we=0 throughout; after release dma_valid=0 and cpu_rdata=0.
- CPU only: write 0xDEADBEEF to address 0x010, then read 0x010 -> ram_we pulses once, cpu_stall stays 0, cpu_rdata=0xDEADBEEF one cycle after the read grant.
- Stream only: dma_req on addresses 0x020..0x023 with the CPU idle -> dma_gnt every cycle, four consecutive dma_valid pulses carrying the preloaded data in order.
- Starvation, MAX_WAIT=8: cpu_req held high and dma_req raised at cycle t -> dma_gnt and cpu_stall both at t+8, dma_valid at t+9, cpu_stall low again at t+9.
- Forced slot over a CPU write: a write to 0x030 is pending when wait_cnt hits the limit -> write deferred one cycle and lands exactly once; a subsequent read of 0x030 returns the written value.
- Contention sweep: random cpu_req/dma_req over 10k cycles -> never two grants in one cycle, no wait exceeds MAX_WAIT+1 cycles, and every granted read returns scoreboard data.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared owner encoding and default starvation limit for ram_arbiter
package ram_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;
  localparam int MAX_WAIT_DEF = 8;
endpackage

// File: rtl/ram_arbiter_starve_counter.sv
// starve_counter: counts consecutive refused cycles of a pending request, saturating at MAX_WAIT
module starve_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pending,
  input  logic granted,
  output logic at_limit
);
  logic [7:0] cnt_q, cnt_d;
  assign at_limit = cnt_q == 8'(MAX_WAIT);
  always_comb cnt_d = (!pending || granted) ? 8'd0 : (at_limit ? cnt_q : cnt_q + 8'd1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous RAM port between the CPU (default priority) and a read-only stream port
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);
  logic   at_limit, force_dma, cpu_gnt;
  owner_t owner_q, owner_d;
  starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk(clk), .rst(rst), .pending(dma_req), .granted(dma_gnt), .at_limit(at_limit)
  );
  assign force_dma = dma_req && at_limit;
  assign cpu_gnt   = cpu_req && !force_dma;
  assign dma_gnt   = dma_req && (!cpu_req || force_dma);
  assign cpu_stall = cpu_req && !cpu_gnt;
  assign ram_addr  = dma_gnt ? dma_addr : cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_we    = cpu_gnt && cpu_we && !rst;
  always_comb owner_d = dma_gnt ? OWN_DMA : ((cpu_gnt && !cpu_we) ? OWN_CPU : OWN_NONE);
  always_ff @(posedge clk) begin
    if (rst) owner_q <= OWN_NONE;
    else owner_q <= owner_d;
  end
  // read data in flight during a reset cycle is discarded
  assign dma_valid = (owner_q == OWN_DMA) && !rst;
  assign dma_rdata = dma_valid ? ram_rdata : '0;
  assign cpu_rdata = ((owner_q == OWN_CPU) && !rst) ? ram_rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vector table, corner sequences and random contention against a shadow-memory model
module tb_ram_arbiter;
  localparam int MAX_WAIT = 8;
  logic        clk = 0, rst, cpu_req, cpu_we, cpu_stall, dma_req, dma_gnt, dma_valid, ram_we;
  logic [9:0]  cpu_addr, dma_addr, ram_addr;
  logic [31:0] cpu_wdata, cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
  logic [31:0] mem [1024];
  logic [31:0] shadow [1024];
  int vecs = 0, errs = 0, mwait = 0, dwait = 0, wcnt30 = 0;
  logic        pv_d = 0, pv_c = 0, s_gnt, s_stall, s_we, s_dv;
  logic [31:0] pd_d, pd_c, s_crd;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .dma_req(dma_req),
    .dma_addr(dma_addr), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_valid(dma_valid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic cr, input logic cw, input logic [9:0] ca,
                      input logic [31:0] cd, input logic dr, input logic [9:0] da);
    logic frc, eg_c, eg_d;
    rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; dma_req = dr; dma_addr = da;
    @(negedge clk);
    frc  = dr && (mwait == MAX_WAIT);
    eg_c = cr && !frc;
    eg_d = dr && (!cr || frc);
    vecs++;
    chk("dma_gnt", 32'(dma_gnt), 32'(eg_d));
    chk("cpu_stall", 32'(cpu_stall), 32'(cr && !eg_c));
    chk("ram_we", 32'(ram_we), 32'(eg_c && cw && !r));
    chk("ram_addr", 32'(ram_addr), 32'(eg_d ? da : ca));
    chk("ram_wdata", ram_wdata, cd);
    chk("dma_valid", 32'(dma_valid), 32'(pv_d && !r));
    chk("dma_rdata", dma_rdata, (pv_d && !r) ? pd_d : 32'h0);
    chk("cpu_rdata", cpu_rdata, (pv_c && !r) ? pd_c : 32'h0);
    if (dma_gnt && cr && !cpu_stall) chk("double_grant", 32'(1), 32'(0));
    dwait = (r || !dr || dma_gnt) ? 0 : dwait + 1;
    if (dwait > MAX_WAIT) chk("wait_bound", 32'(dwait), 32'(MAX_WAIT));
    if (ram_we && ram_addr == 10'h030) wcnt30++;
    s_gnt = dma_gnt; s_stall = cpu_stall; s_we = ram_we; s_dv = dma_valid; s_crd = cpu_rdata;
    @(posedge clk);
    #1;
    if (r) begin
      mwait = 0; pv_d = 0; pv_c = 0;
    end else begin
      pv_d = eg_d; pd_d = shadow[da];
      pv_c = eg_c && !cw; pd_c = shadow[ca];
      if (eg_c && cw) shadow[ca] = cd;
      mwait = (dr && !eg_d) ? mwait + 1 : 0;
    end
  endtask

  typedef struct {
    logic r, cr, cw; logic [9:0] ca; logic [31:0] cd; logic dr; logic [9:0] da;
    logic eg, es, ew, edv; logic [31:0] ecr;
  } vec_t;
  vec_t tbl [18];

  function automatic vec_t mk(logic r, logic cr, logic cw, logic [9:0] ca, logic [31:0] cd,
                              logic dr, logic [9:0] da, logic eg, logic es, logic ew,
                              logic edv, logic [31:0] ecr);
    vec_t v;
    v.r = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.dr = dr; v.da = da;
    v.eg = eg; v.es = es; v.ew = ew; v.edv = edv; v.ecr = ecr;
    return v;
  endfunction

  initial begin
    logic cr, cw, dr;
    logic [9:0] ca, da;
    logic [31:0] cd, val;
    int k;
    tbl[0]  = mk(1, 1, 1, 10'h010, 32'h11111111, 0, 10'h000, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 1, 1, 10'h010, 32'h11111111, 0, 10'h000, 0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 10'h000, 32'h0,        0, 10'h000, 0, 0, 0, 0, 32'h0);
    tbl[3]  = mk(0, 1, 1, 10'h010, 32'hDEADBEEF, 0, 10'h000, 0, 0, 1, 0, 32'h0);
    tbl[4]  = mk(0, 1, 0, 10'h010, 32'h0,        0, 10'h000, 0, 0, 0, 0, 32'h0);
    tbl[5]  = mk(0, 0, 0, 10'h000, 32'h0,        0, 10'h000, 0, 0, 0, 0, 32'hDEADBEEF);
    tbl[6]  = mk(0, 0, 0, 10'h000, 32'h0,        1, 10'h020, 1, 0, 0, 0, 32'h0);
    tbl[7]  = mk(0, 0, 0, 10'h000, 32'h0,        1, 10'h021, 1, 0, 0, 1, 32'h0);
    tbl[8]  = mk(0, 0, 0, 10'h000, 32'h0,        1, 10'h022, 1, 0, 0, 1, 32'h0);
    tbl[9]  = mk(0, 0, 0, 10'h000, 32'h0,        1, 10'h023, 1, 0, 0, 1, 32'h0);
    tbl[10] = mk(0, 0, 0, 10'h000, 32'h0,        0, 10'h000, 0, 0, 0, 1, 32'h0);
    tbl[11] = mk(0, 0, 0, 10'h000, 32'h0,        0, 10'h000, 0, 0, 0, 0, 32'h0);
    tbl[12] = mk(0, 1, 0, 10'h010, 32'h0,        1, 10'h024, 0, 0, 0, 0, 32'h0);
    tbl[13] = mk(0, 0, 0, 10'h000, 32'h0,        1, 10'h024, 1, 0, 0, 0, 32'hDEADBEEF);
    tbl[14] = mk(0, 0, 0, 10'h000, 32'h0,        0, 10'h000, 0, 0, 0, 1, 32'h0);
    tbl[15] = mk(0, 0, 0, 10'h000, 32'h0,        1, 10'h020, 1, 0, 0, 0, 32'h0);
    tbl[16] = mk(1, 0, 0, 10'h000, 32'h0,        0, 10'h000, 0, 0, 0, 0, 32'h0);
    tbl[17] = mk(0, 0, 0, 10'h000, 32'h0,        0, 10'h000, 0, 0, 0, 0, 32'h0);

    step(1, 0, 0, 10'h0, 32'h0, 0, 10'h0);
    for (int i = 0; i < 1024; i++) step(0, 1, 1, 10'(i), $urandom, 0, 10'h0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].dr, tbl[i].da);
      chk($sformatf("tbl%0d_gnt", i), 32'(s_gnt), 32'(tbl[i].eg));
      chk($sformatf("tbl%0d_stall", i), 32'(s_stall), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_we", i), 32'(s_we), 32'(tbl[i].ew));
      chk($sformatf("tbl%0d_dvalid", i), 32'(s_dv), 32'(tbl[i].edv));
      chk($sformatf("tbl%0d_crdata", i), s_crd, tbl[i].ecr);
    end

    k = 0;
    while (k < 20) begin
      step(0, 1, 0, 10'(k), 32'h0, 1, 10'h040);
      if (s_gnt) break;
      k++;
    end
    chk("starve_grant_cycle", 32'(k), 32'(MAX_WAIT));
    chk("starve_stall", 32'(s_stall), 32'(1));
    step(0, 1, 0, 10'h005, 32'h0, 0, 10'h0);
    chk("starve_valid", 32'(s_dv), 32'(1));
    chk("starve_stall_clear", 32'(s_stall), 32'(0));

    val = 32'hCAFE0030;
    wcnt30 = 0;
    for (int i = 0; i < MAX_WAIT; i++) step(0, 1, 0, 10'h001, 32'h0, 1, 10'h050);
    step(0, 1, 1, 10'h030, val, 1, 10'h050);
    chk("fwr_stall", 32'(s_stall), 32'(1));
    chk("fwr_we_deferred", 32'(s_we), 32'(0));
    step(0, 1, 1, 10'h030, val, 0, 10'h0);
    chk("fwr_we_lands", 32'(s_we), 32'(1));
    step(0, 1, 0, 10'h030, 32'h0, 0, 10'h0);
    step(0, 0, 0, 10'h000, 32'h0, 0, 10'h0);
    chk("fwr_readback", s_crd, val);
    chk("fwr_write_once", 32'(wcnt30), 32'(1));

    cr = 0; cw = 0; ca = 0; cd = 0; dr = 0; da = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!s_stall) begin
        cr = 1'($urandom_range(0, 1)); cw = 1'($urandom_range(0, 1));
        ca = 10'($urandom); cd = $urandom;
      end
      if (!dr || s_gnt) begin
        dr = 1'($urandom_range(0, 1)); da = 10'($urandom);
      end
      step(($urandom_range(0, 499) == 0), cr, cw, ca, cd, dr, da);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
